x2050_bc_multi: RTL and testbench
=================================

Name: x2050_bc_multi

Overview:
- Parametrised successor to the 2050 byte counter (BC) for multi-field storage sequencing.
- Holds CH independent W-bit byte counters, each selected per ROS cycle, with the same UP-field semantics as the base BC.
- Adds per-channel sticky wrap detection and a shared LW-bit length counter that counts down on each byte step and flags completion.
- Sits beside the ROS decode; driven by the UP field, a channel select and local-store writeback.

Parameters:
W, 2, width of each byte counter
CH, 2, number of counter channels (>=1)
LW, 8, width of shared length counter
CW, derived = (CH>1) ? $clog2(CH) : 1, channel select width (localparam)

Ports:
i_clk  in  1  system clock
i_reset  in  1  reset; asynchronous, active-high
i_ros_advance  in  1  ROS cycle enable; no state changes when low
i_ch  in  CW  channel selected for this cycle
i_up  in  2  UP field: 0 clear, 1 set all-ones, 2 decrement, 3 increment
i_sel  in  1  apply UP field to selected channel
i_wstb  in  1  load i_newvalue into selected channel
i_newvalue  in  W  value for i_wstb load
i_len_load  in  1  load length counter
i_len_value  in  LW  value for length load
o_bc  out  W  selected channel value (combinational mux of i_ch)
o_bc_all  out  CH*W  all channels; channel k at bits [k*W +: W]
o_wrap  out  1  sticky wrap flag of selected channel (combinational mux)
o_len  out  LW  length counter value
o_len_zero  out  1  o_len == 0 (combinational)
o_done  out  1  registered one-cycle pulse when length reaches 0 by a step

Behaviour:
- Reset (async, active-high): all channels 0, all wrap flags 0, o_len 0, o_done 0. Reset asserted mid-operation overrides everything immediately; no update on the releasing edge.
- All state updates on posedge i_clk gated by i_ros_advance=1. When i_ros_advance=0: counters, wrap flags and length hold; o_done forced 0 on that edge.
- Channel update (selected channel c = i_ch only; other channels hold):
  - i_wstb=1: bc[c] <= i_newvalue; wrap[c] <= 0. Priority over i_sel.
  - else i_sel=1, i_up=0: bc[c] <= 0; wrap[c] <= 0.
  - else i_sel=1, i_up=1: bc[c] <= all ones; wrap[c] <= 0.
  - else i_sel=1, i_up=2: bc[c] <= bc[c]-1 mod 2^W; if bc[c]==0, wrap[c] <= 1, else wrap holds.
  - else i_sel=1, i_up=3: bc[c] <= bc[c]+1 mod 2^W; if bc[c]==all ones, wrap[c] <= 1, else wrap holds.
- i_ch >= CH: no channel changes; o_bc=0, o_wrap=0. A step still counts for length purposes.
- A step is i_sel=1 with i_up in {2,3} and i_wstb=0.
- Length counter:
  - i_len_load=1: o_len <= i_len_value. Load wins over a simultaneous step; no o_done on that edge.
  - else on a step with o_len != 0: o_len <= o_len-1. Saturates at 0; no underflow.
- o_done <= 1 for exactly one cycle on the edge where a step moves o_len from 1 to 0. Otherwise o_done <= 0.
- Zero latency for combinational outputs; the new value appears on the cycle after the qualifying edge.

Test Plan:
- Reset: assert i_reset asynchronously mid-cycle with channels nonzero -> o_bc_all=0, o_wrap=0, o_len=0, o_done=0 immediately.
- Increment wrap, W=2: ch0 at 3, advance with sel/up=3 -> bc0=0, wrap0=1, bc1 unchanged. Then up=0 -> bc0=0, wrap0=0.
- Decrement wrap and write: ch1=0, up=2 -> bc1=3, wrap1=1. Then wstb with newvalue=2 and sel=1/up=3 in the same cycle -> bc1=2 (wstb wins), wrap1=0.
- Advance gating: i_ros_advance=0 with sel/up=3, wstb and len_load all asserted -> no state change, o_done=0.
- Length sequence: len_load 3, then 3 steps (alternating ch0/ch1) -> o_len 2,1,0. o_done pulses exactly once after the third step. A fourth step leaves o_len=0 with no o_done.
- Load/step collision: o_len=1 with len_load=5 and a step in the same cycle -> o_len=5, o_done=0, channel still steps. Out-of-range i_ch (CH=3, i_ch=3) step -> no channel change, o_bc=0, o_len decrements.

Source files
------------

// File: rtl/x2050_bc_multi.sv
// Multi-channel byte counter: CH independent W-bit counters with sticky wrap
// flags, plus a shared LW-bit down-counting length register with done pulse.
module x2050_bc_multi #(
   parameter  int W  = 2,
   parameter  int CH = 2,
   parameter  int LW = 8,
   localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_ros_advance,
   input  logic [CW-1:0]   i_ch,
   input  logic [1:0]      i_up,
   input  logic            i_sel,
   input  logic            i_wstb,
   input  logic [W-1:0]    i_newvalue,
   input  logic            i_len_load,
   input  logic [LW-1:0]   i_len_value,
   output logic [W-1:0]    o_bc,
   output logic [CH*W-1:0] o_bc_all,
   output logic            o_wrap,
   output logic [LW-1:0]   o_len,
   output logic            o_len_zero,
   output logic            o_done
);

   logic [W-1:0]  r_bc [CH];
   logic [CH-1:0] r_wrap;
   logic [LW-1:0] r_len;
   logic          r_done;
   logic [CH-1:0] w_hit;
   logic          w_step;

   // Per-channel decode; an out-of-range select simply hits no channel.
   always_comb begin
      w_hit    = '0;
      o_bc     = '0;
      o_wrap   = 1'b0;
      o_bc_all = '0;
      for (int unsigned k = 0; k < CH; k++) begin
         w_hit[k]             = (i_ch == CW'(k));
         o_bc_all[k*W +: W]   = r_bc[k];
         if (w_hit[k]) begin
            o_bc   = r_bc[k];
            o_wrap = r_wrap[k];
         end
      end
   end

   assign w_step = i_sel & ~i_wstb & i_up[1];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned k = 0; k < CH; k++) r_bc[k] <= '0;
         r_wrap <= '0;
      end else if (i_ros_advance) begin
         for (int unsigned k = 0; k < CH; k++) begin
            if (w_hit[k]) begin
               if (i_wstb) begin
                  r_bc[k]   <= i_newvalue;
                  r_wrap[k] <= 1'b0;
               end else if (i_sel) begin
                  case (i_up)
                     2'd0: begin
                        r_bc[k]   <= '0;
                        r_wrap[k] <= 1'b0;
                     end
                     2'd1: begin
                        r_bc[k]   <= '1;
                        r_wrap[k] <= 1'b0;
                     end
                     2'd2: begin
                        r_bc[k] <= r_bc[k] - 1'b1;
                        if (r_bc[k] == '0) r_wrap[k] <= 1'b1;
                     end
                     default: begin
                        r_bc[k] <= r_bc[k] + 1'b1;
                        if (r_bc[k] == '1) r_wrap[k] <= 1'b1;
                     end
                  endcase
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_len  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_ros_advance) begin
            if (i_len_load) begin
               r_len <= i_len_value;
            end else if (w_step && (r_len != '0)) begin
               r_len <= r_len - 1'b1;
               if (r_len == LW'(1)) r_done <= 1'b1;
            end
         end
      end
   end

   assign o_len      = r_len;
   assign o_len_zero = (r_len == '0);
   assign o_done     = r_done;

endmodule

// File: tb/tb_x2050_bc_multi.sv
// Directed bench for x2050_bc_multi, built with CH=3 so channel select 3 is out of range.
module tb_x2050_bc_multi;

   localparam int W  = 2;
   localparam int CH = 3;
   localparam int LW = 8;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            adv;
   logic [CW-1:0]   ch;
   logic [1:0]      up;
   logic            sel;
   logic            wstb;
   logic [W-1:0]    nv;
   logic            lload;
   logic [LW-1:0]   lval;
   logic [W-1:0]    bc;
   logic [CH*W-1:0] bc_all;
   logic            wrap;
   logic [LW-1:0]   len;
   logic            len_zero;
   logic            done;

   int n_vec = 0;
   int n_err = 0;

   x2050_bc_multi #(.W(W), .CH(CH), .LW(LW)) dut (
      .i_clk(clk), .i_reset(rst), .i_ros_advance(adv), .i_ch(ch), .i_up(up),
      .i_sel(sel), .i_wstb(wstb), .i_newvalue(nv), .i_len_load(lload),
      .i_len_value(lval), .o_bc(bc), .o_bc_all(bc_all), .o_wrap(wrap),
      .o_len(len), .o_len_zero(len_zero), .o_done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; adv = 1'b0; ch = '0; up = '0; sel = 1'b0; wstb = 1'b0;
      nv = '0; lload = 1'b0; lval = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_bc_all", bc_all, 6'b000000);
      chk("rst_wrap", wrap, 1'b0);
      chk("rst_len", len, 8'd0);
      chk("rst_len_zero", len_zero, 1'b1);
      chk("rst_done", done, 1'b0);

      // preload ch0=3, ch1=1
      adv = 1'b1; wstb = 1'b1; ch = 2'd0; nv = 2'd3;
      tick();
      chk("wr_ch0", bc, 2'd3);
      ch = 2'd1; nv = 2'd1;
      tick();
      chk("wr_ch1_all", bc_all, 6'b000111);

      // increment wrap on ch0
      wstb = 1'b0; sel = 1'b1; up = 2'd3; ch = 2'd0;
      tick();
      chk("inc_wrap_all", bc_all, 6'b000100);
      chk("inc_wrap_flag", wrap, 1'b1);
      up = 2'd0;
      tick();
      chk("clr_all", bc_all, 6'b000100);
      chk("clr_wrap", wrap, 1'b0);

      // decrement wrap on ch1, then wstb beats sel
      ch = 2'd1; up = 2'd0;
      tick();
      chk("clr_ch1", bc, 2'd0);
      up = 2'd2;
      tick();
      chk("dec_wrap_all", bc_all, 6'b001100);
      chk("dec_wrap_flag", wrap, 1'b1);
      wstb = 1'b1; nv = 2'd2; up = 2'd3;
      tick();
      chk("wstb_prio_all", bc_all, 6'b001000);
      chk("wstb_prio_wrap", wrap, 1'b0);

      // set-all-ones
      wstb = 1'b0; up = 2'd1; ch = 2'd2;
      tick();
      chk("set_ones_all", bc_all, 6'b111000);
      up = 2'd0;
      tick();
      chk("clr_ch2_all", bc_all, 6'b001000);

      // advance gating
      adv = 1'b0; ch = 2'd1; sel = 1'b1; up = 2'd3; wstb = 1'b1; nv = 2'd1;
      lload = 1'b1; lval = 8'd7;
      tick();
      chk("gate_all", bc_all, 6'b001000);
      chk("gate_wrap", wrap, 1'b0);
      chk("gate_len", len, 8'd0);
      chk("gate_done", done, 1'b0);

      // length sequence
      adv = 1'b1; wstb = 1'b0; sel = 1'b0; lload = 1'b1; lval = 8'd3;
      tick();
      chk("len_load3", len, 8'd3);
      chk("len_load3_done", done, 1'b0);
      lload = 1'b0; sel = 1'b1; up = 2'd3; ch = 2'd0;
      tick();
      chk("len_2", len, 8'd2);
      chk("len_2_done", done, 1'b0);
      up = 2'd2; ch = 2'd1;
      tick();
      chk("len_1", len, 8'd1);
      chk("len_1_done", done, 1'b0);
      up = 2'd3; ch = 2'd0;
      tick();
      chk("len_0", len, 8'd0);
      chk("len_0_zero", len_zero, 1'b1);
      chk("len_0_done", done, 1'b1);
      ch = 2'd1;
      tick();
      chk("len_sat", len, 8'd0);
      chk("len_sat_done", done, 1'b0);
      chk("len_seq_all", bc_all, 6'b001010);

      // load/step collision
      sel = 1'b0; lload = 1'b1; lval = 8'd1;
      tick();
      chk("len_pre1", len, 8'd1);
      lval = 8'd5; sel = 1'b1; up = 2'd3; ch = 2'd0;
      tick();
      chk("coll_len", len, 8'd5);
      chk("coll_done", done, 1'b0);
      chk("coll_all", bc_all, 6'b001011);

      // out-of-range channel step
      lload = 1'b0; ch = 2'd3;
      tick();
      chk("oor_all", bc_all, 6'b001011);
      chk("oor_bc", bc, 2'd0);
      chk("oor_wrap", wrap, 1'b0);
      chk("oor_len", len, 8'd4);

      // sticky wrap survives a further non-wrapping step
      ch = 2'd0;
      tick();
      chk("sticky_set", wrap, 1'b1);
      chk("sticky_bc0", bc, 2'd0);
      tick();
      chk("sticky_hold", wrap, 1'b1);
      chk("sticky_len", len, 8'd2);

      // async reset mid-cycle
      #2;
      rst = 1'b1;
      #1;
      chk("arst_all", bc_all, 6'b000000);
      chk("arst_wrap", wrap, 1'b0);
      chk("arst_len", len, 8'd0);
      chk("arst_done", done, 1'b0);
      tick();
      chk("arst_hold_all", bc_all, 6'b000000);
      rst = 1'b0; adv = 1'b0;
      tick();
      chk("post_rst_len", len, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
